// File: rtl/tag_alloc_ctrl_pkg.sv
// Shared rename constants for the regfile, ROB and tag allocator.
package tag_alloc_ctrl_pkg;

  localparam int robSize  = 16;
  localparam int tagWidth = 5;
  localparam int regWidth = 5;

  localparam logic [tagWidth-1:0] emptyTag = tagWidth'(robSize);
  localparam logic [regWidth-1:0] emptyReg = '0;
  localparam logic [tagWidth:0]   robCount = (tagWidth+1)'(robSize);

  // Ring-pointer increment; wrap is explicit so robSize need not be 2^n.
  function automatic logic [tagWidth-1:0] next_ptr(input logic [tagWidth-1:0] p);
    return (p == tagWidth'(robSize - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/tag_alloc_ctrl.sv
// Rename-tag allocator: hands out ROB tags in ring order at the tail and
// retires them in order at the head. Out-of-order or empty commits are
// dropped and latch a sticky error flag.
module tag_alloc_ctrl
  import tag_alloc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                clear,
  input  logic                issue_valid,
  input  logic [regWidth-1:0] issue_rd,
  output logic                issue_ready,
  output logic [tagWidth-1:0] alloc_tag,
  output logic [regWidth-1:0] reg_to_rename,
  output logic [tagWidth-1:0] tag_rename,
  input  logic                commit_valid,
  input  logic [tagWidth-1:0] commit_tag,
  output logic [tagWidth-1:0] head_tag,
  output logic [tagWidth:0]   count,
  output logic                empty,
  output logic                full,
  output logic                err
);

  logic [tagWidth-1:0] r_head;
  logic [tagWidth-1:0] r_tail;
  logic [tagWidth:0]   r_count;
  logic                r_err;

  logic w_active;
  logic w_empty;
  logic w_full;
  logic w_issue_ready;
  logic w_issue_fire;
  logic w_commit_fire;
  logic w_commit_bad;

  // Ready/fire qualification; a full pool stays full even if a commit
  // frees a slot this cycle, which keeps issue_ready off the commit path.
  always_comb begin
    w_active      = rdy && !clear;
    w_empty       = (r_count == '0);
    w_full        = (r_count == robCount);
    w_issue_ready = w_active && !w_full;
    w_issue_fire  = issue_valid && w_issue_ready;
    w_commit_fire = w_active && commit_valid && !w_empty && (commit_tag == r_head);
    w_commit_bad  = w_active && commit_valid && (w_empty || (commit_tag != r_head));
  end

  // Output decode, all combinational from state and current inputs.
  always_comb begin
    issue_ready   = w_issue_ready;
    alloc_tag     = w_issue_ready ? r_tail : emptyTag;
    reg_to_rename = (w_issue_fire && (issue_rd != emptyReg)) ? issue_rd : emptyReg;
    tag_rename    = w_issue_fire ? r_tail : emptyTag;
    head_tag      = w_empty ? emptyTag : r_head;
    count         = r_count;
    empty         = w_empty;
    full          = w_full;
    err           = r_err;
  end

  // Pointer/count/error state; rst beats clear, clear beats issue/commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (rdy) begin
      if (clear) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_issue_fire)  r_tail <= next_ptr(r_tail);
        if (w_commit_fire) r_head <= next_ptr(r_head);
        if (w_issue_fire && !w_commit_fire)      r_count <= r_count + 1'b1;
        else if (!w_issue_fire && w_commit_fire) r_count <= r_count - 1'b1;
        if (w_commit_bad) r_err <= 1'b1;
      end
    end
  end

endmodule
